// File: rtl/search_controller.sv
// search_controller
// Splits a 24-bit key space across NUM_CORES datapath cores. It launches all
// of them, collects their done reports, and stops the rest as soon as one
// core finds the key. The result is then held for the user.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   go                  start request (level), honoured in IDLE and REPORT
//   core_start          one-cycle launch pulse to every core
//   core_done           per-core done, held high by the core until acked
//   core_done_ack       per-core one-cycle acknowledge
//   core_found/core_key per-core result, valid while core_done is high
//   core_key_start/end  per-core key range, 24 bits per core, core i at [24i+:24]
//   core_stop           broadcast stop while other cores are drained
//   busy, done          search in progress / result available
//   key_found, found_key, found_core   latched search result
//   o_dbg_state         current FSM state
//
// Done/ack handshake: a core raises core_done and holds it, together with
// core_found and core_key. The controller samples done on a clock edge and
// drives core_done_ack high for exactly the following cycle. The core may
// take one cycle to drop done after seeing the ack. For that reason, done is
// ignored from a core whose ack is currently high. Done is also ignored from
// any core already retired in this search.
module search_controller #(
  parameter int          NUM_CORES = 4,
  parameter logic [23:0] KEY_MAX   = 24'h3FFFFF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    go,
  output logic [NUM_CORES-1:0]    core_start,
  input  logic [NUM_CORES-1:0]    core_done,
  output logic [NUM_CORES-1:0]    core_done_ack,
  input  logic [NUM_CORES-1:0]    core_found,
  input  logic [24*NUM_CORES-1:0] core_key,
  output logic [24*NUM_CORES-1:0] core_key_start,
  output logic [24*NUM_CORES-1:0] core_key_end,
  output logic                    core_stop,
  output logic                    busy,
  output logic                    done,
  output logic                    key_found,
  output logic [23:0]             found_key,
  output logic [2:0]              found_core,
  output logic [2:0]              o_dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LAUNCH   = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_STOP_ALL = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_REPORT   = 3'd5;

  localparam int SLICE = (int'(KEY_MAX) + 1) / NUM_CORES;

  logic [2:0]              r_state;
  logic                    r_armed;
  logic [NUM_CORES-1:0]    r_core_start;
  logic [NUM_CORES-1:0]    r_core_done_ack;
  logic                    r_core_stop;
  logic [NUM_CORES-1:0]    r_retired;
  logic                    r_key_found;
  logic [23:0]             r_found_key;
  logic [2:0]              r_found_core;
  logic [24*NUM_CORES-1:0] r_key_start;
  logic [24*NUM_CORES-1:0] r_key_end;

  logic [24*NUM_CORES-1:0] w_start_vec;
  logic [24*NUM_CORES-1:0] w_end_vec;
  logic                    w_accept;
  logic [NUM_CORES-1:0]    w_new;
  logic [NUM_CORES-1:0]    w_found_new;
  logic [NUM_CORES-1:0]    w_retired_nxt;
  logic                    w_all_retired;
  logic                    w_any_found;
  logic [2:0]              w_win_idx;
  logic [23:0]             w_win_key;

  // Constant range table. The last core absorbs any remainder of the division.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_rng
    localparam int RNG_START = g * SLICE;
    localparam int RNG_END   = (g == NUM_CORES - 1) ? int'(KEY_MAX) : (g + 1) * SLICE - 1;
    assign w_start_vec[24*g +: 24] = 24'(RNG_START);
    assign w_end_vec[24*g +: 24]   = 24'(RNG_END);
  end

  assign w_accept      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_new         = w_accept ? (core_done & ~r_retired & ~r_core_done_ack) : '0;
  // Found flags count only while running; anything reported during drain is discarded.
  assign w_found_new   = (r_state == S_RUN) ? (w_new & core_found) : '0;
  assign w_retired_nxt = r_retired | w_new;
  assign w_all_retired = &w_retired_nxt;

  // Lowest-index winner: scan downward so the last hit written is the lowest.
  always_comb begin
    w_any_found = 1'b0;
    w_win_idx   = '0;
    w_win_key   = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_found_new[i]) begin
        w_any_found = 1'b1;
        w_win_idx   = 3'(i);
        w_win_key   = core_key[24*i +: 24];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_armed         <= 1'b0;
      r_core_start    <= '0;
      r_core_done_ack <= '0;
      r_core_stop     <= 1'b0;
      r_retired       <= '0;
      r_key_found     <= 1'b0;
      r_found_key     <= '0;
      r_found_core    <= '0;
      r_key_start     <= '0;
      r_key_end       <= '0;
    end else begin
      // r_armed makes the first edge after reset release ignore go.
      r_armed         <= 1'b1;
      r_core_start    <= '0;
      r_core_done_ack <= w_new;
      r_retired       <= w_retired_nxt;
      case (r_state)
        S_IDLE, S_REPORT: begin
          if (go && (r_armed || r_state == S_REPORT)) begin
            r_state      <= S_LAUNCH;
            r_core_start <= '1;
            r_retired    <= '0;
            r_key_found  <= 1'b0;
            r_found_key  <= '0;
            r_found_core <= '0;
            r_key_start  <= w_start_vec;
            r_key_end    <= w_end_vec;
          end
        end
        S_LAUNCH: r_state <= S_RUN;
        S_RUN: begin
          if (w_any_found) begin
            r_state      <= S_STOP_ALL;
            r_key_found  <= 1'b1;
            r_found_key  <= w_win_key;
            r_found_core <= w_win_idx;
            r_core_stop  <= 1'b1;
          end else if (w_all_retired) begin
            r_state <= S_REPORT;
          end
        end
        S_STOP_ALL: r_state <= S_DRAIN;
        S_DRAIN: begin
          if (w_all_retired) begin
            r_state     <= S_REPORT;
            r_core_stop <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core_start     = r_core_start;
  assign core_done_ack  = r_core_done_ack;
  assign core_stop      = r_core_stop;
  assign core_key_start = r_key_start;
  assign core_key_end   = r_key_end;
  assign busy           = (r_state == S_LAUNCH) || (r_state == S_RUN) ||
                          (r_state == S_STOP_ALL) || (r_state == S_DRAIN);
  assign done           = (r_state == S_REPORT);
  assign key_found      = r_key_found;
  assign found_key      = r_found_key;
  assign found_core     = r_found_core;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_search_controller.sv
module tb_search_controller;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LAUNCH   = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_STOP_ALL = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_REPORT   = 3'd5;

  logic        clk;
  logic        reset_n;
  logic        go;
  logic [3:0]  core_start;
  logic [3:0]  core_done;
  logic [3:0]  core_done_ack;
  logic [3:0]  core_found;
  logic [95:0] core_key;
  logic [95:0] core_key_start;
  logic [95:0] core_key_end;
  logic        core_stop;
  logic        busy;
  logic        done;
  logic        key_found;
  logic [23:0] found_key;
  logic [2:0]  found_core;
  logic [2:0]  o_dbg_state;

  search_controller dut (
    .clk(clk), .reset_n(reset_n), .go(go),
    .core_start(core_start), .core_done(core_done), .core_done_ack(core_done_ack),
    .core_found(core_found), .core_key(core_key),
    .core_key_start(core_key_start), .core_key_end(core_key_end),
    .core_stop(core_stop), .busy(busy), .done(done), .key_found(key_found),
    .found_key(found_key), .found_core(found_core), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int stop_cycles = 0;
  logic [3:0]  start_q[$];
  logic [3:0]  ack_q[$];
  logic [27:0] res_q[$];   // {key_found, found_core, found_key}
  logic [23:0] exp_rs[4];
  logic [23:0] exp_re[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- core responder: drop done after ack ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (core_done_ack[i]) begin
          core_done[i]  = 1'b0;
          core_found[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_done;
    logic [3:0]  e4;
    logic [27:0] er;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        if (core_stop) stop_cycles++;
        if (core_start != 4'h0) begin
          if (start_q.size() == 0) check("start_unexpected", 64'(core_start), 64'h0);
          else begin
            e4 = start_q.pop_front();
            check("core_start", 64'(core_start), 64'(e4));
            for (int i = 0; i < 4; i++) begin
              check($sformatf("range_start%0d", i), 64'(core_key_start[24*i +: 24]), 64'(exp_rs[i]));
              check($sformatf("range_end%0d", i), 64'(core_key_end[24*i +: 24]), 64'(exp_re[i]));
            end
          end
        end
        if (core_done_ack != 4'h0) begin
          if (ack_q.size() == 0) check("ack_unexpected", 64'(core_done_ack), 64'h0);
          else begin
            e4 = ack_q.pop_front();
            check("core_done_ack", 64'(core_done_ack), 64'(e4));
          end
        end
        if (done && !prev_done) begin
          if (res_q.size() == 0) check("report_unexpected", 64'h1, 64'h0);
          else begin
            er = res_q.pop_front();
            check("result", 64'({key_found, found_core, found_key}), 64'(er));
            check("stop_in_report", 64'(core_stop), 64'h0);
          end
        end
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input logic [2:0] s, input string name);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (o_dbg_state == s) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check({"timeout_", name}, 64'(o_dbg_state), 64'(s));
  endtask

  // Raise done on the masked cores at a negedge; optionally check the ack
  // appears right after the sampling edge.
  task automatic raise_done(input logic [3:0] mask, input logic [3:0] fnd,
                            input logic [95:0] keys, input bit chk_lat);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        core_done[i]          = 1'b1;
        core_found[i]         = fnd[i];
        core_key[24*i +: 24]  = keys[24*i +: 24];
      end
    end
    if (chk_lat) begin
      @(posedge clk);
      #1;
      check("ack_latency", 64'(core_done_ack & mask), 64'(mask));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 64'(o_dbg_state), 64'(S_IDLE));
    check({tag, "_outs"}, 64'({core_start, core_done_ack, core_stop, busy, done, key_found}), 64'h0);
    check({tag, "_result"}, 64'({found_core, found_key}), 64'h0);
    check({tag, "_ranges"}, 64'(|{core_key_start, core_key_end}), 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stop_before;
    exp_rs = '{24'h000000, 24'h100000, 24'h200000, 24'h300000};
    exp_re = '{24'h0FFFFF, 24'h1FFFFF, 24'h2FFFFF, 24'h3FFFFF};
    reset_n = 1'b0; go = 1'b0;
    core_done = '0; core_found = '0; core_key = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: four cores finish without a find, staggered.
    start_q.push_back(4'hF);
    go = 1'b1;
    wait_state(S_LAUNCH, "t1_launch");
    check("t1_busy", 64'(busy), 64'h1);
    go = 1'b0;
    wait_state(S_RUN, "t1_run");
    stop_before = stop_cycles;
    ack_q.push_back(4'b0100); ack_q.push_back(4'b0001);
    ack_q.push_back(4'b1000); ack_q.push_back(4'b0010);
    res_q.push_back({1'b0, 3'd0, 24'h000000});
    raise_done(4'b0100, 4'b0000, 96'h0, 1'b1);
    repeat (3) @(negedge clk);
    raise_done(4'b0001, 4'b0000, 96'h0, 1'b1);
    repeat (2) @(negedge clk);
    raise_done(4'b1000, 4'b0000, 96'h0, 1'b1);
    raise_done(4'b0010, 4'b0000, 96'h0, 1'b1);
    wait_state(S_REPORT, "t1_report");
    check("t1_no_stop", 64'(stop_cycles - stop_before), 64'h0);

    // Test 2: core 2 finds the key; the rest are drained under core_stop.
    start_q.push_back(4'hF);
    go = 1'b1;
    wait_state(S_LAUNCH, "t2_launch");
    go = 1'b0;
    wait_state(S_RUN, "t2_run");
    ack_q.push_back(4'b0100);
    raise_done(4'b0100, 4'b0100, {24'h0, 24'h2A0001, 48'h0}, 1'b1);
    check("t2_stop_all", 64'(o_dbg_state), 64'(S_STOP_ALL));
    check("t2_stop_set", 64'(core_stop), 64'h1);
    wait_state(S_DRAIN, "t2_drain");
    ack_q.push_back(4'b0001); ack_q.push_back(4'b0010); ack_q.push_back(4'b1000);
    res_q.push_back({1'b1, 3'd2, 24'h2A0001});
    // A late found flag from core 0 must not replace the result.
    raise_done(4'b0001, 4'b0001, {72'h0, 24'h000777}, 1'b1);
    repeat (2) @(negedge clk);
    raise_done(4'b0010, 4'b0000, 96'h0, 1'b1);
    @(negedge clk);
    check("t2_stop_held", 64'(core_stop), 64'h1);
    raise_done(4'b1000, 4'b0000, 96'h0, 1'b1);
    wait_state(S_REPORT, "t2_report");
    check("t2_range_held", 64'(core_key_end[24*2 +: 24]), 64'h2FFFFF);

    // Test 3: two finds in one cycle; go held high throughout.
    start_q.push_back(4'hF);
    go = 1'b1;
    wait_state(S_LAUNCH, "t3_launch");
    check("t3_cleared", 64'({key_found, found_core, found_key}), 64'h0);
    wait_state(S_RUN, "t3_run");
    ack_q.push_back(4'b1010);
    raise_done(4'b1010, 4'b1010, {24'h3000FF, 24'h0, 24'h100010, 24'h0}, 1'b1);
    check("t3_go_ignored", 64'(o_dbg_state), 64'(S_STOP_ALL));
    wait_state(S_DRAIN, "t3_drain");
    ack_q.push_back(4'b0101);
    res_q.push_back({1'b1, 3'd1, 24'h100010});
    start_q.push_back(4'hF);   // go still high: REPORT relaunches at once
    raise_done(4'b0101, 4'b0000, 96'h0, 1'b1);
    wait_state(S_LAUNCH, "t3_relaunch");
    check("t3_relaunch_cleared", 64'({key_found, found_core, found_key}), 64'h0);
    go = 1'b0;

    // Test 4: reset in the middle of DRAIN, then a normal search.
    wait_state(S_RUN, "t4_run");
    ack_q.push_back(4'b0001);
    raise_done(4'b0001, 4'b0001, {72'h0, 24'h000123}, 1'b1);
    wait_state(S_DRAIN, "t4_drain");
    reset_n = 1'b0;
    core_done = '0; core_found = '0; core_key = '0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    start_q.push_back(4'hF);
    go = 1'b1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_idle", 64'(o_dbg_state), 64'(S_IDLE));
    check("first_edge_no_start", 64'(core_start), 64'h0);
    @(posedge clk);
    #1;
    check("second_edge_launch", 64'(o_dbg_state), 64'(S_LAUNCH));
    @(negedge clk);
    go = 1'b0;
    wait_state(S_RUN, "t4b_run");
    ack_q.push_back(4'hF);
    res_q.push_back({1'b0, 3'd0, 24'h000000});
    raise_done(4'hF, 4'h0, 96'h0, 1'b1);
    wait_state(S_REPORT, "t4b_report");
    repeat (2) @(negedge clk);

    check("start_q_empty", 64'(start_q.size()), 64'h0);
    check("ack_q_empty", 64'(ack_q.size()), 64'h0);
    check("res_q_empty", 64'(res_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/search_controller.md
SEARCH_CONTROLLER -- requirements
Module: search_controller

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of datapath cores driven (1..8).
REQ-002 SHALL have parameter KEY_MAX, default 24'h3FFFFF, highest key in the search space.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 go  input  1  user request to start a search; level, sampled in IDLE/REPORT only.
REQ-006 core_start  output  NUM_CORES  per-core datapath_start.
REQ-007 core_done  input  NUM_CORES  per-core datapath_done; held high until acked.
REQ-008 core_done_ack  output  NUM_CORES  per-core datapath_done_ack.
REQ-009 core_found  input  NUM_CORES  per-core secret_key_found_flag; valid while core_done high.
REQ-010 core_key  input  24*NUM_CORES  per-core secret_key; core i at bits [24i+23:24i]; valid while core_done high.
REQ-011 core_key_start, core_key_end  output  24*NUM_CORES each  per-core key range, same packing.
REQ-012 core_stop  output  1  broadcast stop to all cores.
REQ-013 busy  output  1  high from LAUNCH through DRAIN.
REQ-014 done  output  1  high in REPORT.
REQ-015 key_found  output  1  search result valid and key found; qualified by done.
REQ-016 found_key  output  24  winning key; qualified by key_found.
REQ-017 found_core  output  3  index of winning core; qualified by key_found.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, RUN, STOP_ALL, DRAIN, REPORT.
REQ-019 Ranges: slice = (KEY_MAX+1)/NUM_CORES; core i start = i*slice, end = (i+1)*slice-1; last core end = KEY_MAX; latched in LAUNCH, held stable until next LAUNCH.
REQ-020 IDLE: go=1 -> LAUNCH next cycle; retired mask and result registers cleared on this transition.
REQ-021 LAUNCH: core_start all ones for exactly one cycle, then RUN.
REQ-022 RUN: core with core_done=1 and not retired is retired; core_done_ack for that core is high exactly one cycle, the cycle after done is first sampled.
REQ-023 An acked core's done is ignored for one cycle after ack (deassertion latency); no double ack.
REQ-024 Retired core with core_found=0: no other effect; when all cores retired with no find -> REPORT, key_found=0.
REQ-025 Retired core with core_found=1: latch found_key/found_core, key_found=1, go to STOP_ALL.
REQ-026 Several cores reporting found in the same cycle: lowest index wins; others acked and discarded.
REQ-027 STOP_ALL: core_stop=1 for one cycle, then DRAIN.
REQ-028 DRAIN: core_stop held high; each remaining core acked on done per REQ-022; later found flags ignored; all retired -> REPORT with core_stop low.
REQ-029 REPORT: done=1, result held; go=1 -> LAUNCH (new search); go=0 -> stay.
REQ-030 go in LAUNCH/RUN/STOP_ALL/DRAIN SHALL be ignored.
REQ-031 core_start, core_done_ack, core_stop SHALL be registered outputs, glitch-free.

Reset
REQ-032 reset_n=0 at any time, including mid-search: state IDLE; core_start, core_done_ack, core_stop, busy, done, key_found, found_key, found_core, retired mask all zero; ranges zero.
REQ-033 First cycle after reset release SHALL be IDLE regardless of go; go sampled from the following edge.

Verification
REQ-034 Defaults, go pulse -> core_start=4'hF one cycle; ranges 000000-0FFFFF, 100000-1FFFFF, 200000-2FFFFF, 300000-3FFFFF.
REQ-035 All four cores done, found=0, staggered cycles -> one ack per core, then done=1, key_found=0, core_stop never asserted.
REQ-036 Core 2 done with found=1, key 24'h2A0001 -> core_stop high until cores 0,1,3 done and acked; REPORT with found_key=24'h2A0001, found_core=2.
REQ-037 Cores 1 and 3 done and found same cycle (keys 24'h100010, 24'h3000FF) -> found_core=1, found_key=24'h100010, both acked once.
REQ-038 reset_n low during DRAIN -> all outputs zero immediately; after release, go -> normal LAUNCH.
REQ-039 go held high in RUN and REPORT -> ignored in RUN; new LAUNCH from REPORT with cleared result.
